// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fir_pkg
//  Brief    : Shared FSM state type, default widths and accumulator sizing.
//  Revision : 1.0
// ============================================================================
package fir_pkg;

    localparam int FIR_DW   = 8;
    localparam int FIR_CW   = 8;
    localparam int FIR_TAPS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        HOLD = 2'd2
    } fir_state_t;

    // Product width plus log2(TAPS) guard bits: the sum of TAPS products cannot overflow.
    function automatic int acc_width(input int dw, input int cw, input int taps);
        return dw + cw + $clog2(taps);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_mac_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : fir_mac_sequencer_if
//  Brief    : Sample, coefficient, multiplier and result buses of the FIR sequencer.
//  Revision : 1.0
// ============================================================================
interface fir_mac_sequencer_if
    import fir_pkg::*;
#(
    parameter int DW   = FIR_DW,
    parameter int CW   = FIR_CW,
    parameter int TAPS = FIR_TAPS
);
    localparam int AW = acc_width(DW, CW, TAPS);
    localparam int KW = $clog2(TAPS);

    logic               in_valid;
    logic               in_ready;
    logic [DW-1:0]      in_data;
    logic               coef_we;
    logic [KW-1:0]      coef_addr;
    logic [CW-1:0]      coef_data;
    logic               coef_err;
    logic [DW-1:0]      mul_a;
    logic [CW-1:0]      mul_b;
    logic               mul_p;
    logic [DW+CW-1:0]   mul_op;
    logic               out_valid;
    logic               out_ready;
    logic [AW-1:0]      out_data;
    logic               busy;

    // Environment side: sample source, coefficient writer, multiplier and sink.
    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_data, mul_op, out_ready,
        input  in_ready, coef_err, mul_a, mul_b, mul_p, out_valid, out_data, busy
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_data, mul_op, out_ready,
        output in_ready, coef_err, mul_a, mul_b, mul_p, out_valid, out_data, busy
    );

endinterface
`default_nettype wire

// File: rtl/fir_sample_ring.sv
`default_nettype none
// ============================================================================
//  Module   : fir_sample_ring
//  Brief    : Circular sample delay line with write pointer and tap-offset read.
//  Revision : 1.0
// ============================================================================
module fir_sample_ring #(
    parameter int DW   = 8,
    parameter int TAPS = 8
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    input  wire logic                      wr_en,
    input  wire logic [DW-1:0]             wr_data,
    input  wire logic                      advance,
    input  wire logic [$clog2(TAPS)-1:0]   rd_offset,
    output logic      [DW-1:0]             rd_data
);
    localparam int KW = $clog2(TAPS);

    logic [DW-1:0] r_ring [TAPS];
    logic [KW-1:0] r_wr_ptr;
    logic [KW-1:0] w_rd_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            for (int i = 0; i < TAPS; i++) begin
                r_ring[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                r_ring[r_wr_ptr] <= wr_data;
            end
            if (advance) begin
                r_wr_ptr <= r_wr_ptr + KW'(1);
            end
        end
    end

    // TAPS is a power of two, so the subtraction wraps exactly like mod TAPS.
    assign w_rd_idx = r_wr_ptr - rd_offset;
    assign rd_data  = r_ring[w_rd_idx];

endmodule
`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fir_mac_sequencer
//  Brief    : Time-multiplexed FIR controller driving one shared external multiplier.
//  Revision : 1.0
// ============================================================================
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int DW     = FIR_DW,
    parameter int CW     = FIR_CW,
    parameter int TAPS   = FIR_TAPS,
    parameter int SIGNED = 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    fir_mac_sequencer_if.slave bus
);
    localparam int AW = acc_width(DW, CW, TAPS);
    localparam int KW = $clog2(TAPS);
    localparam int PW = DW + CW;

    fir_state_t      r_state;
    fir_state_t      w_state_next;
    logic [KW-1:0]   r_k;
    logic [KW-1:0]   w_k_next;
    logic [AW-1:0]   r_acc;
    logic [AW-1:0]   r_out_data;
    logic [DW-1:0]   r_mul_a;
    logic [CW-1:0]   r_mul_b;
    logic [CW-1:0]   r_coef [TAPS];
    logic            r_coef_err;
    logic            w_accept;
    logic            w_last;
    logic            w_ext_bit;
    logic [AW-1:0]   w_prod_ext;
    logic [AW-1:0]   w_sum;
    logic [DW-1:0]   w_ring_rd;

    assign w_accept   = bus.in_valid && (r_state == IDLE);
    assign w_last     = (r_state == MAC) && (r_k == KW'(TAPS - 1));
    assign w_k_next   = r_k + KW'(1);
    assign w_ext_bit  = (SIGNED != 0) ? bus.mul_op[PW-1] : 1'b0;
    assign w_prod_ext = {{(AW - PW){w_ext_bit}}, bus.mul_op};
    assign w_sum      = r_acc + w_prod_ext;

    fir_sample_ring #(
        .DW   (DW),
        .TAPS (TAPS)
    ) u_ring (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (w_accept),
        .wr_data   (bus.in_data),
        .advance   (w_last),
        .rd_offset (w_k_next),
        .rd_data   (w_ring_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)      w_state_next = MAC;
            MAC:     if (w_last)        w_state_next = HOLD;
            HOLD:    if (bus.out_ready) w_state_next = IDLE;
            default:                    w_state_next = IDLE;
        endcase
    end

    // Writes are only honoured in IDLE, so an in-flight computation sees frozen coefficients.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                r_coef[i] <= '0;
            end
        end else if (bus.coef_we && (r_state == IDLE)) begin
            r_coef[bus.coef_addr] <= bus.coef_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k        <= '0;
            r_acc      <= '0;
            r_out_data <= '0;
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_coef_err <= 1'b0;
        end else begin
            r_coef_err <= bus.coef_we && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_acc   <= '0;
                        r_k     <= '0;
                        // Tap 0 is the sample being written this edge; a same-edge write to h[0] wins.
                        r_mul_a <= bus.in_data;
                        r_mul_b <= (bus.coef_we && (bus.coef_addr == '0)) ? bus.coef_data : r_coef[0];
                    end
                end
                MAC: begin
                    r_acc <= w_sum;
                    if (w_last) begin
                        r_out_data <= w_sum;
                        r_k        <= '0;
                        r_mul_a    <= '0;
                        r_mul_b    <= '0;
                    end else begin
                        r_k     <= w_k_next;
                        r_mul_a <= w_ring_rd;
                        r_mul_b <= r_coef[w_k_next];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_valid = (r_state == HOLD);
    assign bus.out_data  = r_out_data;
    assign bus.coef_err  = r_coef_err;
    assign bus.mul_a     = r_mul_a;
    assign bus.mul_b     = r_mul_b;
    assign bus.mul_p     = (SIGNED != 0);

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_mac_sequencer
//  Brief    : Self-checking bench with a direct-form convolution reference model.
//  Revision : 1.0
// ============================================================================
module tb_fir_mac_sequencer;
    localparam int DW   = 8;
    localparam int CW   = 8;
    localparam int TAPS = 8;
    localparam int AW   = DW + CW + $clog2(TAPS);

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    int              m_coef [TAPS];
    int              m_hist [TAPS];
    logic [AW-1:0]   m_expected;

    fir_mac_sequencer_if #(.DW(DW), .CW(CW), .TAPS(TAPS)) bus ();

    fir_mac_sequencer #(.DW(DW), .CW(CW), .TAPS(TAPS), .SIGNED(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Multiplier stand-in: full-width product, two's complement when mul_p is set.
    logic signed [DW+CW-1:0] ms_a, ms_b;
    logic        [DW+CW-1:0] mu_a, mu_b;
    always_comb begin
        ms_a       = $signed(bus.mul_a);
        ms_b       = $signed(bus.mul_b);
        mu_a       = {{CW{1'b0}}, bus.mul_a};
        mu_b       = {{DW{1'b0}}, bus.mul_b};
        bus.mul_op = bus.mul_p ? ms_a * ms_b : mu_a * mu_b;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < TAPS; i++) begin
            m_coef[i] = 0;
            m_hist[i] = 0;
        end
        m_expected = '0;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    task automatic write_coef(input int addr, input logic [CW-1:0] val);
        bus.coef_we   = 1'b1;
        bus.coef_addr = addr[$clog2(TAPS)-1:0];
        bus.coef_data = val;
        @(negedge clk);
        bus.coef_we = 1'b0;
        m_coef[addr] = int'($signed(val));
    endtask

    // Present a sample (optionally with a coefficient write on the same edge) and
    // update the model; returns at the negedge after the accepting edge.
    task automatic accept(input logic [DW-1:0] val, input bit we, input int addr,
                          input logic [CW-1:0] cval);
        int wait_cnt;
        longint y;
        bus.in_valid = 1'b1;
        bus.in_data  = val;
        if (we) begin
            bus.coef_we   = 1'b1;
            bus.coef_addr = addr[$clog2(TAPS)-1:0];
            bus.coef_data = cval;
        end
        wait_cnt = 0;
        while (!bus.in_ready && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.coef_we  = 1'b0;
        if (we) m_coef[addr] = int'($signed(cval));
        for (int i = TAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = int'($signed(val));
        y = 0;
        for (int i = 0; i < TAPS; i++) y += longint'(m_coef[i]) * longint'(m_hist[i]);
        m_expected = y[AW-1:0];
    endtask

    // Counts cycles from the accept cycle (cycle 0) until out_valid is seen; 0 on timeout.
    task automatic wait_out(input int start, output logic [AW-1:0] got, output int lat);
        lat = start;
        while (!bus.out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        got = bus.out_data;
        if (!bus.out_valid) lat = 0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({bus.in_ready, bus.out_valid, bus.coef_err, bus.busy} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b need 1000", {bus.in_ready, bus.out_valid, bus.coef_err, bus.busy});
        end
        tests_run++;
        if ({bus.mul_a, bus.mul_b, bus.out_data} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: mul_a=%0h mul_b=%0h out=%0h need 0", bus.mul_a, bus.mul_b, bus.out_data);
        end
    endtask

    task automatic test_impulse();
        logic [AW-1:0] got;
        int lat;
        do_reset();
        for (int i = 0; i < TAPS; i++) write_coef(i, CW'(i + 1));
        for (int n = 0; n <= TAPS; n++) begin
            accept((n == 0) ? DW'(1) : DW'(0), 1'b0, 0, '0);
            wait_out(1, got, lat);
            tests_run++;
            if (got !== m_expected || got !== AW'((n < TAPS) ? n + 1 : 0) || lat != TAPS + 1) begin
                tests_failed++;
                $display("FAIL impulse[%0d]: got %0d lat %0d need %0d lat %0d", n, got, lat, m_expected, TAPS + 1);
            end
            drain();
            tests_run++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL impulse_release[%0d]: out_valid=%b in_ready=%b need 0/1", n, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_signed();
        logic [AW-1:0] got;
        int lat;
        do_reset();
        for (int i = 0; i < TAPS; i++) write_coef(i, 8'h80);
        for (int n = 0; n < TAPS; n++) begin
            accept(8'h80, 1'b0, 0, '0);
            wait_out(1, got, lat);
            tests_run++;
            if (got !== m_expected) begin
                tests_failed++;
                $display("FAIL signed[%0d]: got %0d need %0d", n, got, m_expected);
            end
            drain();
        end
        tests_run++;
        if (got !== AW'(131072)) begin
            tests_failed++;
            $display("FAIL signed_full: got %0d need 131072", got);
        end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] got;
        int lat;
        int bad;
        bus.out_ready = 1'b0;
        accept(DW'($urandom), 1'b0, 0, '0);
        wait_out(1, got, lat);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.out_data !== m_expected || bus.in_ready || !bus.busy) bad++;
        end
        tests_run++;
        if (bad != 0 || got !== m_expected) begin
            tests_failed++;
            $display("FAIL backpressure_hold: %0d bad cycles, out=%0d need %0d", bad, bus.out_data, m_expected);
        end
        drain();
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b need 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_coef_err();
        logic [AW-1:0] got;
        int lat;
        for (int i = 0; i < TAPS; i++) write_coef(i, CW'($urandom));
        accept(DW'($urandom_range(1, 255)), 1'b0, 0, '0);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 3'd3;
        bus.coef_data = CW'(m_coef[3] + 7);
        @(negedge clk);
        bus.coef_we = 1'b0;
        tests_run++;
        if (bus.coef_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL coef_err_pulse: got %b need 1", bus.coef_err);
        end
        @(negedge clk);
        tests_run++;
        if (bus.coef_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL coef_err_clear: got %b need 0", bus.coef_err);
        end
        wait_out(3, got, lat);
        tests_run++;
        if (got !== m_expected) begin
            tests_failed++;
            $display("FAIL coef_err_result: got %0d need %0d", got, m_expected);
        end
        drain();
        accept(DW'($urandom), 1'b0, 0, '0);
        wait_out(1, got, lat);
        tests_run++;
        if (got !== m_expected) begin
            tests_failed++;
            $display("FAIL coef_err_retained: got %0d need %0d", got, m_expected);
        end
        drain();
    endtask

    task automatic test_wrap();
        logic [AW-1:0] got;
        int lat;
        do_reset();
        for (int i = 0; i < TAPS; i++) write_coef(i, 8'd1);
        for (int n = 1; n <= 20; n++) begin
            accept(DW'(n), 1'b0, 0, '0);
            wait_out(1, got, lat);
            tests_run++;
            if (got !== m_expected) begin
                tests_failed++;
                $display("FAIL wrap[%0d]: got %0d need %0d", n, got, m_expected);
            end
            drain();
        end
        tests_run++;
        if (got !== AW'(132)) begin
            tests_failed++;
            $display("FAIL wrap_last: got %0d need 132", got);
        end
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] got;
        int lat;
        for (int i = 0; i < TAPS; i++) write_coef(i, CW'($urandom_range(1, 255)));
        accept(DW'($urandom_range(1, 255)), 1'b0, 0, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.busy, bus.in_ready, bus.out_valid} !== 3'b010 || {bus.mul_a, bus.mul_b, bus.out_data} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid: busy=%b in_ready=%b mul_a=%0h mul_b=%0h need 0/1/0/0",
                     bus.busy, bus.in_ready, bus.mul_a, bus.mul_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        for (int i = 0; i < TAPS; i++) write_coef(i, CW'($urandom));
        accept(DW'($urandom), 1'b0, 0, '0);
        wait_out(1, got, lat);
        tests_run++;
        if (got !== m_expected) begin
            tests_failed++;
            $display("FAIL reset_mid_next: got %0d need %0d", got, m_expected);
        end
        drain();
    endtask

    task automatic test_random();
        logic [AW-1:0] got;
        int lat;
        bit we;
        for (int n = 0; n < 30; n++) begin
            we = ($urandom_range(0, 3) == 0);
            accept(DW'($urandom), we, $urandom_range(0, TAPS - 1), CW'($urandom));
            bus.out_ready = ($urandom_range(0, 1) == 1);
            wait_out(1, got, lat);
            tests_run++;
            if (got !== m_expected || lat != TAPS + 1) begin
                tests_failed++;
                $display("FAIL random[%0d]: got %0d lat %0d need %0d lat %0d", n, got, lat, m_expected, TAPS + 1);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            drain();
            if ($urandom_range(0, 4) == 0) write_coef($urandom_range(0, TAPS - 1), CW'($urandom));
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_impulse();
        test_signed();
        test_backpressure();
        test_coef_err();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
